// File: rtl/mini_mips_cpu_pkg.sv
// rtl/mini_mips_cpu_pkg.sv - shared opcodes, field widths and FP constants for mini_mips_cpu
package mini_mips_cpu_pkg;
  localparam int REG_W     = 5;
  localparam int ADDR_W    = 10;
  localparam int MEM_DEPTH = 1024;
  localparam int NUM_REGS  = 32;

  localparam int          FP_BIAS = 127;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_ADDI  = 6'b000001,
    OP_LW    = 6'b000010,
    OP_SW    = 6'b000011,
    OP_BEQ   = 6'b000100,
    OP_LUI   = 6'b001011,
    OP_MFC1  = 6'b100000,
    OP_MTC1  = 6'b100001,
    OP_ADDS  = 6'b100010,
    OP_SUBS  = 6'b100011
  } opcode_t;

  typedef enum logic [5:0] {
    FN_ADD = 6'b000000,
    FN_SUB = 6'b000001,
    FN_AND = 6'b000010,
    FN_OR  = 6'b000011,
    FN_XOR = 6'b000100,
    FN_SLT = 6'b000101,
    FN_MUL = 6'b001100
  } funct_t;
endpackage

// File: rtl/mini_mips_cpu_fp_addsub.sv
// rtl/mini_mips_cpu_fp_addsub.sv - combinational single-precision add/subtract, truncating
module mini_mips_cpu_fp_addsub
  import mini_mips_cpu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] result
);
  logic        special;
  logic [23:0] ma, mb;
  logic        swap;
  logic        big_s, sml_s;
  logic [7:0]  big_e, sml_e, d;
  logic [23:0] big_m, sml_m;
  logic [4:0]  d_cap;
  logic [53:0] shifted;
  logic [26:0] aligned;
  logic [27:0] sum;
  logic [26:0] norm;
  logic [4:0]  lz;
  logic signed [9:0] exp_n;
  logic        unused_bits;

  // Subnormals flush to zero by dropping the hidden bit and fraction.
  assign special = (&a[30:23]) | (&b[30:23]);
  assign ma = (a[30:23] != 8'd0) ? {1'b1, a[22:0]} : 24'd0;
  assign mb = (b[30:23] != 8'd0) ? {1'b1, b[22:0]} : 24'd0;
  assign swap = {b[30:23], mb} > {a[30:23], ma};

  assign big_s = swap ? (b[31] ^ sub) : a[31];
  assign sml_s = swap ? a[31] : (b[31] ^ sub);
  assign big_e = swap ? b[30:23] : a[30:23];
  assign sml_e = swap ? a[30:23] : b[30:23];
  assign big_m = swap ? mb : ma;
  assign sml_m = swap ? ma : mb;
  assign d     = big_e - sml_e;
  assign d_cap = (d > 8'd27) ? 5'd27 : d[4:0];

  // Shifted-out bits collapse into the sticky position (bit 0).
  assign shifted = {sml_m, 3'b000, 27'd0} >> d_cap;
  assign aligned = {shifted[53:28], shifted[27] | (|shifted[26:0])};
  assign sum = (big_s ^ sml_s) ? ({1'b0, big_m, 3'b000} - {1'b0, aligned})
                               : ({1'b0, big_m, 3'b000} + {1'b0, aligned});

  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (sum[i]) lz = 5'(26 - i);
    end
    if (sum[27]) begin
      norm  = {sum[27:2], sum[1] | sum[0]};
      exp_n = $signed({2'b00, big_e}) + 10'sd1;
    end else begin
      norm  = sum[26:0] << lz;
      exp_n = $signed({2'b00, big_e}) - $signed({5'd0, lz});
    end
    if (special)                result = FP_QNAN;
    else if (sum == 28'd0)      result = 32'd0;
    else if (exp_n >= 10'sd255) result = {big_s, 8'hFF, 23'd0};
    else if (exp_n <= 10'sd0)   result = 32'd0;
    else                        result = {big_s, exp_n[7:0], norm[25:3]};
  end

  assign unused_bits = ^{norm[26], norm[2:0], exp_n[9:8]};
endmodule

// File: rtl/mini_mips_cpu.sv
// rtl/mini_mips_cpu.sv - single-cycle MIPS-style core with GPR/FPR files and on-chip memories
module mini_mips_cpu
  import mini_mips_cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       inst_data,
  input  logic [ADDR_W-1:0] address,
  input  logic              write_instruction,
  input  logic              write_data,
  output logic [31:0]       OutputOfRs
);
  logic [31:0] imem [MEM_DEPTH];
  logic [31:0] dmem [MEM_DEPTH];
  logic [31:0] gpr  [NUM_REGS];
  logic [31:0] fpr  [NUM_REGS];
  logic [ADDR_W-1:0] pc, next_pc, maddr;

  logic [31:0]      ins;
  opcode_t          op;
  funct_t           funct;
  logic [REG_W-1:0] ra, rb, rc;
  logic [15:0]      imm;
  logic [31:0]      a_val, b_val, c_val, fp_res;

  logic        gpr_we, fpr_we, dmem_we;
  logic [31:0] gpr_wd, fpr_wd;

  assign ins   = imem[pc];
  assign op    = opcode_t'(ins[31:26]);
  assign funct = funct_t'(ins[5:0]);
  assign ra    = ins[25:21];
  assign rb    = ins[20:16];
  assign rc    = ins[15:11];
  assign imm   = ins[15:0];

  assign a_val = (ra == '0) ? 32'd0 : gpr[ra];
  assign b_val = (rb == '0) ? 32'd0 : gpr[rb];
  assign c_val = (rc == '0) ? 32'd0 : gpr[rc];
  assign OutputOfRs = b_val;

  // Low 10 bits of base + sign-extended offset are just the low 10 bits of each.
  assign maddr = b_val[ADDR_W-1:0] + imm[ADDR_W-1:0];

  mini_mips_cpu_fp_addsub u_fp_addsub (
    .a      (fpr[rb]),
    .b      (fpr[rc]),
    .sub    (op == OP_SUBS),
    .result (fp_res)
  );

  always_comb begin
    gpr_we  = 1'b0;
    gpr_wd  = 32'd0;
    fpr_we  = 1'b0;
    fpr_wd  = 32'd0;
    dmem_we = 1'b0;
    next_pc = pc + 10'd1;
    case (op)
      OP_RTYPE: begin
        gpr_we = 1'b1;
        case (funct)
          FN_ADD:  gpr_wd = b_val + c_val;
          FN_SUB:  gpr_wd = b_val - c_val;
          FN_AND:  gpr_wd = b_val & c_val;
          FN_OR:   gpr_wd = b_val | c_val;
          FN_XOR:  gpr_wd = b_val ^ c_val;
          FN_SLT:  gpr_wd = {31'd0, $signed(b_val) < $signed(c_val)};
          FN_MUL:  gpr_wd = b_val * c_val;
          default: gpr_we = 1'b0;
        endcase
      end
      OP_ADDI: begin gpr_we = 1'b1; gpr_wd = b_val + {16'd0, imm}; end
      OP_LUI:  begin gpr_we = 1'b1; gpr_wd = {imm, 16'd0}; end
      OP_LW:   begin gpr_we = 1'b1; gpr_wd = dmem[maddr]; end
      OP_SW:   dmem_we = 1'b1;
      OP_BEQ:  if (a_val == b_val) next_pc = pc + 10'd1 + imm[ADDR_W-1:0];
      OP_MFC1: begin gpr_we = 1'b1; gpr_wd = fpr[rb]; end
      OP_MTC1: begin fpr_we = 1'b1; fpr_wd = b_val; end
      OP_ADDS, OP_SUBS: begin fpr_we = 1'b1; fpr_wd = fp_res; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        gpr[i] <= '0;
        fpr[i] <= '0;
      end
    end else begin
      pc <= next_pc;
      if (gpr_we && ra != '0) gpr[ra] <= gpr_wd;
      if (fpr_we) fpr[ra] <= fpr_wd;
    end
  end

  // Memories survive reset; the load port only works while the core is held.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (write_instruction) imem[address] <= inst_data;
      if (write_data) dmem[address] <= inst_data;
    end else if (dmem_we) begin
      dmem[maddr] <= a_val;
    end
  end
endmodule

// File: tb/tb_mini_mips_cpu.sv
// tb/tb_mini_mips_cpu.sv - scoreboard bench for mini_mips_cpu
module tb_mini_mips_cpu;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] inst_data = 32'd0;
  logic [9:0]  address = 10'd0;
  logic        write_instruction = 1'b0;
  logic        write_data = 1'b0;
  logic [31:0] OutputOfRs;

  int checks = 0;
  int errors = 0;

  localparam int K_GPR = 0, K_FPR = 1, K_DMEM = 2, K_PC = 3;

  typedef struct {
    string       tag;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  logic [31:0] prog [34];

  mini_mips_cpu dut (
    .clk               (clk),
    .rst               (rst),
    .inst_data         (inst_data),
    .address           (address),
    .write_instruction (write_instruction),
    .write_data        (write_data),
    .OutputOfRs        (OutputOfRs)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] i_op(input logic [5:0] op, input int a, input int b,
                                       input logic [15:0] imm);
    return {op, 5'(a), 5'(b), imm};
  endfunction

  function automatic logic [31:0] r_op(input logic [5:0] op, input int a, input int b,
                                       input int c, input logic [5:0] fn);
    return {op, 5'(a), 5'(b), 5'(c), 5'd0, fn};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int kind, input int idx, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.kind = kind; e.idx = idx; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_GPR:   obs = dut.gpr[e.idx];
        K_FPR:   obs = dut.fpr[e.idx];
        K_DMEM:  obs = dut.dmem[e.idx];
        default: obs = {22'd0, dut.pc};
      endcase
      check(e.tag, obs, e.exp);
    end
  endtask

  task automatic load(input logic [9:0] addr, input logic [31:0] word, input logic imem_en,
                      input logic dmem_en);
    @(negedge clk);
    address = addr;
    inst_data = word;
    write_instruction = imem_en;
    write_data = dmem_en;
    @(negedge clk);
    write_instruction = 1'b0;
    write_data = 1'b0;
  endtask

  task automatic push_program_results();
    push("gpr31", K_GPR, 31, 32'h40228F5C);
    push("gpr30", K_GPR, 30, 32'h4183D70A);
    push("fpr1", K_FPR, 1, 32'h40228F5C);
    push("fpr2", K_FPR, 2, 32'h4183D70A);
    push("fpr3_add", K_FPR, 3, 32'h419828F5);
    push("gpr1_mfc1", K_GPR, 1, 32'h419828F5);
    push("fpr4_sub", K_FPR, 4, 32'hC15F0A3D);
    push("gpr2", K_GPR, 2, 32'd10);
    push("gpr3", K_GPR, 3, 32'd8);
    push("gpr4_mul", K_GPR, 4, 32'd80);
    push("gpr0_zero", K_GPR, 0, 32'd0);
    push("gpr9_skipped", K_GPR, 9, 32'd0);
    push("gpr10_skipped", K_GPR, 10, 32'd0);
    push("gpr11_target", K_GPR, 11, 32'd3);
    push("gpr6_lw", K_GPR, 6, 32'hDEADBEEF);
    push("dmem7_sw", K_DMEM, 7, 32'hDEADBEEF);
    push("fpr6_cancel", K_FPR, 6, 32'h00000000);
    push("fpr8_ovf", K_FPR, 8, 32'h7F800000);
    push("fpr9_nan", K_FPR, 9, 32'h7FC00000);
    push("gpr12_sub", K_GPR, 12, 32'hFFFFFFFE);
    push("gpr13_slt", K_GPR, 13, 32'd1);
    push("gpr14_xor", K_GPR, 14, 32'd2);
    push("gpr15_or", K_GPR, 15, 32'd10);
    push("gpr16_and", K_GPR, 16, 32'd8);
    push("pc_loop", K_PC, 0, 32'd33);
  endtask

  initial begin
    prog[0]  = i_op(6'h01, 1, 0, 16'h0000);
    prog[1]  = i_op(6'h0B, 31, 0, 16'h4022);
    prog[2]  = i_op(6'h01, 31, 31, 16'h8F5C);
    prog[3]  = i_op(6'h0B, 30, 0, 16'h4183);
    prog[4]  = i_op(6'h01, 30, 30, 16'hD70A);
    prog[5]  = i_op(6'h21, 2, 30, 16'h0000);
    prog[6]  = i_op(6'h21, 1, 31, 16'h0000);
    prog[7]  = r_op(6'h22, 3, 2, 1, 6'h00);
    prog[8]  = r_op(6'h23, 4, 1, 2, 6'h00);
    prog[9]  = i_op(6'h20, 1, 3, 16'h0000);
    prog[10] = i_op(6'h01, 2, 0, 16'd10);
    prog[11] = i_op(6'h01, 3, 0, 16'd8);
    prog[12] = r_op(6'h00, 4, 2, 3, 6'h0C);
    prog[13] = i_op(6'h01, 0, 0, 16'd5);
    prog[14] = i_op(6'h04, 0, 0, 16'd2);
    prog[15] = i_op(6'h01, 9, 0, 16'd1);
    prog[16] = i_op(6'h01, 10, 0, 16'd1);
    prog[17] = i_op(6'h01, 11, 0, 16'd3);
    prog[18] = i_op(6'h02, 6, 0, 16'd5);
    prog[19] = i_op(6'h03, 6, 0, 16'd7);
    prog[20] = i_op(6'h0B, 5, 0, 16'h3F80);
    prog[21] = i_op(6'h21, 5, 5, 16'h0000);
    prog[22] = r_op(6'h23, 6, 5, 5, 6'h00);
    prog[23] = i_op(6'h0B, 7, 0, 16'h7F7F);
    prog[24] = i_op(6'h01, 7, 7, 16'hFFFF);
    prog[25] = i_op(6'h21, 7, 7, 16'h0000);
    prog[26] = r_op(6'h22, 8, 7, 7, 6'h00);
    prog[27] = r_op(6'h22, 9, 8, 7, 6'h00);
    prog[28] = r_op(6'h00, 12, 3, 2, 6'h01);
    prog[29] = r_op(6'h00, 13, 12, 2, 6'h05);
    prog[30] = r_op(6'h00, 14, 2, 3, 6'h04);
    prog[31] = r_op(6'h00, 15, 2, 3, 6'h03);
    prog[32] = r_op(6'h00, 16, 2, 3, 6'h02);
    prog[33] = i_op(6'h04, 0, 0, 16'hFFFF);

    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      address = 10'(i);
      inst_data = 32'd0;
      write_instruction = 1'b1;
      write_data = 1'b1;
    end
    @(negedge clk);
    write_instruction = 1'b0;
    write_data = 1'b0;

    for (int i = 0; i < 34; i++) load(10'(i), prog[i], 1'b1, 1'b0);
    load(10'd5, 32'hDEADBEEF, 1'b0, 1'b1);
    push_program_results();

    // Enables while running must not touch memory.
    @(negedge clk);
    check("reset_pc", {22'd0, dut.pc}, 32'd0);
    check("reset_rs", OutputOfRs, 32'd0);
    rst = 1'b1;
    address = 10'd40;
    inst_data = 32'h12345678;
    write_instruction = 1'b1;
    write_data = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    write_instruction = 1'b0;
    write_data = 1'b0;
    drain();
    check("imem40_ignored", dut.imem[40], 32'd0);
    check("dmem40_ignored", dut.dmem[40], 32'd0);

    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rs_mid", OutputOfRs, 32'h40220000);
    repeat (4) @(posedge clk);
    #1;
    check("pc_before_abort", {22'd0, dut.pc}, 32'd6);
    rst = 1'b0;
    #1;
    check("abort_pc", {22'd0, dut.pc}, 32'd0);
    check("abort_gpr31", dut.gpr[31], 32'd0);
    check("abort_fpr2", dut.fpr[2], 32'd0);
    check("abort_imem0", dut.imem[0], prog[0]);
    check("abort_dmem7", dut.dmem[7], 32'hDEADBEEF);

    push_program_results();
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
